imem_program_loader: RTL and testbench

- Boot-time writer that fills the pipelined core's instruction memory from a valid/ready word stream, starting at a programmable base PC, e.g. 200.
- After the last word is written it releases the core: it raises core_run and presents core_pc = base address.
- Sits between the bench/host stream source and the imem write port, ahead of the fetch stage.

---
 rtl/imem_program_loader.sv | 164 ++++++++++++++++
 tb/tb_imem_program_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// Boot-time instruction memory loader: streams words into imem from a base PC, then releases the core.
// Optional LOADER_CHECKSUM_EN adds expected_sum/sum_err and gates core_run on a matching word sum.
module imem_program_loader #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
`ifdef LOADER_CHECKSUM_EN
    input  logic [DATA_W-1:0] expected_sum,
    output logic              sum_err,
`endif
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              core_run,
    output logic [ADDR_W-1:0] core_pc
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              xfer;
    logic [ADDR_W-1:0] base_aligned;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              sum_err_q, sum_err_d;
    logic [DATA_W-1:0] sum_next;
`endif

    assign xfer         = in_valid && in_ready_q;
    assign base_aligned = {base_addr[ADDR_W-1:2], 2'b00};
`ifdef LOADER_CHECKSUM_EN
    assign sum_next     = sum_q + in_data;
`endif

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        in_ready_d = in_ready_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        exp_d      = exp_q;
        sum_err_d  = sum_err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (load_start) begin
                    base_d   = base_aligned;
                    addr_d   = base_aligned;
                    remain_d = word_count;
`ifdef LOADER_CHECKSUM_EN
                    sum_d     = '0;
                    exp_d     = expected_sum;
                    sum_err_d = 1'b0;
`endif
                    if (word_count == '0) begin
                        state_d    = S_DONE;
                        in_ready_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        sum_err_d  = (expected_sum != '0);
`endif
                    end else begin
                        state_d    = S_LOAD;
                        in_ready_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    we_d     = 1'b1;
                    waddr_d  = addr_q;
                    wdata_d  = in_data;
                    addr_d   = addr_q + ADDR_W'(4);
                    remain_d = remain_q - CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                    sum_d    = sum_next;
`endif
                    // Last word: stop accepting now; its write lands in the first DONE cycle.
                    if (remain_q == CNT_W'(1)) begin
                        state_d    = S_DONE;
                        in_ready_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        sum_err_d  = (sum_next != exp_q);
`endif
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            addr_q     <= '0;
            remain_q   <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
            exp_q      <= '0;
            sum_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            exp_q      <= exp_d;
            sum_err_q  <= sum_err_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q == S_LOAD);
    assign done       = (state_q == S_DONE);
    assign core_pc    = base_q;
`ifdef LOADER_CHECKSUM_EN
    assign sum_err    = sum_err_q;
    assign core_run   = (state_q == S_DONE) && !sum_err_q;
`else
    assign core_run   = (state_q == S_DONE);
`endif

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: table of loads plus reset/restart sequence.
// Define LOADER_CHECKSUM_EN to also exercise the checksum ports.
module tb_imem_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, imem_we, busy, done, core_run;
    logic [31:0] imem_addr, imem_wdata, core_pc;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] expected_sum = '0;
    logic        sum_err;
`endif

    imem_program_loader dut (
        .clk(clk), .rst(rst), .load_start(load_start), .base_addr(base_addr),
        .word_count(word_count), .in_data(in_data), .in_valid(in_valid),
`ifdef LOADER_CHECKSUM_EN
        .expected_sum(expected_sum), .sum_err(sum_err),
`endif
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done),
        .core_run(core_run), .core_pc(core_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      base;
        logic [15:0]      cnt;
        logic [7:0]       vpat;   // in_valid per streaming cycle, bit0 first
        bit               poke;   // pulse load_start during LOAD
        bit               bad;    // supply a wrong expected_sum
        logic [3:0][31:0] w;
    } vec_t;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

    int  nvec = 0;
    int  nerr = 0;
    int  we_cnt = 0;
    wr_t sb[$];
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && imem_we) begin
            we_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_write", 64'(imem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 64'(imem_addr), 64'(e.addr));
                chk("wr_data", 64'(imem_wdata), 64'(e.data));
            end
        end
    end

    task automatic run_load(input vec_t v);
        logic [31:0] eb;
        logic [31:0] s;
        bit          exp_run;
        int          k, cyc, w0;
        bit          drove;
        eb = {v.base[31:2], 2'b00};
        s = '0;
        for (int i = 0; i < 4; i++) if (i < int'(v.cnt)) s = s + v.w[i];
        exp_run = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        expected_sum = v.bad ? s + 32'd1 : s;
        exp_run = !v.bad;
`endif
        w0 = we_cnt;
        load_start = 1'b1; base_addr = v.base; word_count = v.cnt;
        tick();
        load_start = 1'b0;
        if (v.cnt != 0) begin
            chk("start_in_ready", 64'(in_ready), 64'd1);
            chk("start_busy", 64'(busy), 64'd1);
            chk("start_core_run", 64'(core_run), 64'd0);
            k = 0; cyc = 0;
            while (k < int'(v.cnt) && cyc < 64) begin
                chk("in_ready_load", 64'(in_ready), 64'd1);
                drove = v.vpat[cyc % 8];
                in_valid = drove;
                in_data = v.w[k];
                if (v.poke && cyc == 0) begin
                    load_start = 1'b1; base_addr = 32'h0000_0500; word_count = 16'd9;
                end
                if (drove) sb.push_back('{addr: eb + 32'(4 * k), data: v.w[k]});
                tick();
                load_start = 1'b0;
                chk("we_timing", 64'(imem_we), 64'(drove));
                if (drove) k++;
                cyc++;
            end
            in_valid = 1'b0;
            chk("load_timeout", 64'(k), 64'(v.cnt));
        end else begin
            chk("zero_we", 64'(imem_we), 64'd0);
        end
        chk("done", 64'(done), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        chk("core_run", 64'(core_run), 64'(exp_run));
        chk("core_pc", 64'(core_pc), 64'(eb));
        chk("in_ready_end", 64'(in_ready), 64'd0);
`ifdef LOADER_CHECKSUM_EN
        chk("sum_err", 64'(sum_err), 64'(v.bad));
`endif
        tick();
        chk("we_after", 64'(imem_we), 64'd0);
        chk("write_count", 64'(we_cnt - w0), 64'(v.cnt));
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs.push_back('{base: 32'd200, cnt: 16'd3, vpat: 8'hFF, poke: 0, bad: 0,
                         w: {32'h0, 32'h02329820, 32'h2012000A, 32'h20110005}});
        vecs.push_back('{base: 32'd200, cnt: 16'd3, vpat: 8'b1110_1001, poke: 0, bad: 0,
                         w: {32'h0, 32'h02329820, 32'h2012000A, 32'h20110005}});
        vecs.push_back('{base: 32'd203, cnt: 16'd0, vpat: 8'hFF, poke: 0, bad: 0,
                         w: {32'h0, 32'h0, 32'h0, 32'h0}});
        vecs.push_back('{base: 32'hFFFF_FFFC, cnt: 16'd2, vpat: 8'hFF, poke: 0, bad: 0,
                         w: {32'h0, 32'h0, 32'h1234_5678, 32'hDEAD_BEEF}});
        vecs.push_back('{base: 32'h0000_1003, cnt: 16'd4, vpat: 8'b1011_0110, poke: 1, bad: 0,
                         w: {32'hA5A5_0004, 32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001}});
`ifdef LOADER_CHECKSUM_EN
        vecs.push_back('{base: 32'h40, cnt: 16'd3, vpat: 8'hFF, poke: 0, bad: 0,
                         w: {32'h0, 32'd3, 32'd2, 32'd1}});
        vecs.push_back('{base: 32'h40, cnt: 16'd3, vpat: 8'hFF, poke: 0, bad: 1,
                         w: {32'h0, 32'd3, 32'd2, 32'd1}});
        vecs.push_back('{base: 32'h80, cnt: 16'd0, vpat: 8'hFF, poke: 0, bad: 1,
                         w: {32'h0, 32'h0, 32'h0, 32'h0}});
`endif

        repeat (2) tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_we", 64'(imem_we), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_core_run", 64'(core_run), 64'd0);
        chk("idle_core_pc", 64'(core_pc), 64'd0);
        chk("idle_addr", 64'(imem_addr), 64'd0);

        for (int i = 0; i < vecs.size(); i++) run_load(vecs[i]);

        // Reset after two of four words have been accepted.
        load_start = 1'b1; base_addr = 32'h300; word_count = 16'd4;
        tick();
        load_start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 32'hC0DE_0000 + 32'(i);
            sb.push_back('{addr: 32'h300 + 32'(4 * i), data: in_data});
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_we", 64'(imem_we), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_core_run", 64'(core_run), 64'd0);
        chk("mid_rst_addr", 64'(imem_addr), 64'd0);
        chk("mid_rst_wdata", 64'(imem_wdata), 64'd0);
        chk("mid_rst_core_pc", 64'(core_pc), 64'd0);
        chk("mid_rst_sb", 64'(sb.size()), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        v = '{base: 32'h100, cnt: 16'd2, vpat: 8'hFF, poke: 1, bad: 0,
              w: {32'h0, 32'h0, 32'h0BAD_F00D, 32'h1357_9BDF}};
        run_load(v);

        chk("final_sb", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
